// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: RAM-backed instruction memory with a registered valid/ready fetch path
// and a runtime program-load port.
module imem_fetch_unit #(
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH = 64,
   parameter int DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_INSN = 32'h00000013
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   output logic req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic rsp_valid,
   input  logic rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic rsp_fault,
   input  logic prog_en,
   input  logic prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   output logic prog_err,
   output logic [$clog2(DEPTH):0] load_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] RUN = 1'b0;
   localparam logic [0:0] LOAD = 1'b1;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [0:0] state;
   logic [ADDR_WIDTH-3:0] idx;
   logic [AW-1:0] rd_idx;
   logic pending, accept, fault, wr_ok, wr;
   // Power-up image only; rst deliberately leaves the program intact.
   initial for (int i = 0; i < DEPTH; i++) mem[i] = NOP_INSN;
   always_comb begin
      idx = req_addr[ADDR_WIDTH-1:2];
      rd_idx = AW'(idx);
      pending = rsp_valid && !rsp_ready;
      req_ready = (state == RUN) && !pending && !prog_en;
      accept = req_valid && req_ready;
      fault = (req_addr[1:0] != 2'b00) || (32'(idx) >= DEPTH);
      wr = (state == LOAD) && prog_we;
      wr_ok = 32'(prog_addr) < DEPTH;
   end
   always_ff @(posedge clk) if (wr && wr_ok) mem[prog_addr] <= prog_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         rsp_valid <= 1'b0;
         rsp_data <= NOP_INSN;
         rsp_fault <= 1'b0;
         prog_err <= 1'b0;
         load_count <= '0;
      end else begin
         prog_err <= wr && !wr_ok;
         if (state == RUN && prog_en && !pending) begin
            state <= LOAD;
            load_count <= '0;
         end else if (state == LOAD && !prog_en) state <= RUN;
         if (wr && wr_ok && load_count != (AW+1)'(DEPTH)) load_count <= load_count + 1'b1;
         if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data <= fault ? NOP_INSN : mem[rd_idx];
            rsp_fault <= fault;
         end else if (rsp_ready) rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed table-driven bench for imem_fetch_unit (ADDR_WIDTH=10, DEPTH=48).
module tb_imem_fetch_unit;
   localparam int AW = 10;
   localparam int DP = 48;
   localparam logic [31:0] NOP = 32'h00000013;
   logic clk = 0, rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault;
   logic prog_en, prog_we, prog_err;
   logic [AW-1:0] req_addr;
   logic [31:0] rsp_data, prog_data;
   logic [5:0] prog_addr;
   logic [6:0] load_count;
   int checks = 0, failures = 0;

   imem_fetch_unit #(.ADDR_WIDTH(AW), .DEPTH(DP), .DATA_WIDTH(32), .NOP_INSN(NOP)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
      .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .prog_err(prog_err), .load_count(load_count));

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0] data;
      logic flt;
   } vec_t;
   vec_t vt [9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      prog_we = 1; prog_addr = a; prog_data = d;
      step();
      prog_we = 0;
   endtask

   initial begin
      vt[0] = '{10'h004, 32'h00100093, 1'b0};
      vt[1] = '{10'h008, 32'h00500093, 1'b0};
      vt[2] = '{10'h0BC, 32'h00a00113, 1'b0};
      vt[3] = '{10'h006, NOP, 1'b1};
      vt[4] = '{10'h0C0, NOP, 1'b1};
      vt[5] = '{10'h100, NOP, 1'b1};
      vt[6] = '{10'h3FC, NOP, 1'b1};
      vt[7] = '{10'h000, NOP, 1'b0};
      vt[8] = '{10'h001, NOP, 1'b1};
      rst = 1; req_valid = 0; req_addr = 0; rsp_ready = 1;
      prog_en = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
      step(); step();
      rst = 0;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_load_count", 32'(load_count), 0);
      chk("rst_rsp_data", rsp_data, NOP);
      chk("rst_prog_err", 32'(prog_err), 0);
      chk("rst_req_ready", 32'(req_ready), 1);
      req_valid = 1; req_addr = 0;
      step();
      req_valid = 0;
      chk("f0_valid", 32'(rsp_valid), 1);
      chk("f0_data", rsp_data, NOP);
      chk("f0_fault", 32'(rsp_fault), 0);
      step();
      chk("f0_clear", 32'(rsp_valid), 0);
      prog_en = 1;
      step();
      chk("load_req_ready", 32'(req_ready), 0);
      wr(6'd1, 32'h00100093);
      wr(6'd2, 32'h00500093);
      wr(6'd47, 32'h00a00113);
      chk("load_count3", 32'(load_count), 3);
      prog_en = 0;
      step();
      chk("run_req_ready", 32'(req_ready), 1);
      for (int i = 0; i < 9; i++) begin
         req_valid = 1; req_addr = vt[i].addr;
         step();
         chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 1);
         chk($sformatf("vec%0d_data", i), rsp_data, vt[i].data);
         chk($sformatf("vec%0d_fault", i), 32'(rsp_fault), 32'(vt[i].flt));
      end
      req_valid = 0;
      step();
      // Backpressure: response held while a second request waits.
      rsp_ready = 0; req_valid = 1; req_addr = 10'h004;
      step();
      req_addr = 10'h008;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("hold%0d_data", i), rsp_data, 32'h00100093);
         chk($sformatf("hold%0d_valid", i), 32'(rsp_valid), 1);
         chk($sformatf("hold%0d_req_ready", i), 32'(req_ready), 0);
         step();
      end
      req_valid = 0; rsp_ready = 1;
      #1;
      chk("hold_release_ready", 32'(req_ready), 1);
      step();
      chk("hold_consumed", 32'(rsp_valid), 0);
      // prog_en while a response is pending: stay in RUN, ignore writes.
      req_valid = 1; req_addr = 10'h008; rsp_ready = 0;
      step();
      req_valid = 0; prog_en = 1;
      step();
      chk("pend_req_ready", 32'(req_ready), 0);
      chk("pend_valid", 32'(rsp_valid), 1);
      chk("pend_data", rsp_data, 32'h00500093);
      prog_we = 1; prog_addr = 6'd5; prog_data = 32'hDEADBEEF;
      step();
      chk("run_we_no_err", 32'(prog_err), 0);
      chk("run_we_no_count", 32'(load_count), 3);
      rsp_ready = 1;
      step();
      prog_we = 0;
      chk("enter_load_valid", 32'(rsp_valid), 0);
      chk("enter_load_count", 32'(load_count), 0);
      wr(6'd48, 32'hFFFFFFFF);
      chk("oob_prog_err", 32'(prog_err), 1);
      chk("oob_load_count", 32'(load_count), 0);
      step();
      chk("oob_err_pulse", 32'(prog_err), 0);
      wr(6'd0, NOP);
      chk("oob_then_ok_count", 32'(load_count), 1);
      prog_en = 0;
      step();
      req_valid = 1; req_addr = 10'h014;
      step();
      chk("run_write_ignored", rsp_data, NOP);
      req_addr = 10'h000;
      step();
      req_valid = 0;
      chk("addr0_unchanged", rsp_data, NOP);
      step();
      prog_en = 1;
      step();
      for (int i = 0; i < 50; i++) wr(6'd10, NOP);
      chk("load_count_sat", 32'(load_count), DP);
      prog_en = 0;
      step();
      // Reset with a stalled response.
      req_valid = 1; req_addr = 10'h004; rsp_ready = 0;
      step();
      req_valid = 0;
      chk("pre_rst_valid", 32'(rsp_valid), 1);
      rst = 1;
      step();
      rst = 0;
      chk("mid_rst_valid", 32'(rsp_valid), 0);
      chk("mid_rst_count", 32'(load_count), 0);
      rsp_ready = 1; req_valid = 1; req_addr = 10'h004;
      step();
      req_valid = 0;
      chk("survive_data", rsp_data, 32'h00100093);
      chk("survive_fault", 32'(rsp_fault), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
